// File: rtl/mc_control_unit_v2.sv
// mc_control_unit_v2: multicycle control FSM for the MIPS-subset CPU.
// Adds imem/dmem ready handshakes with a wait-state timeout, sticky HALT/ERR
// states, illegal-opcode trapping and a retired-instruction counter.
// All strobes and fields are combinational and forced low while rst is high.
module mc_control_unit_v2 #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             InsMemRW,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             mRD,
    output logic             mWR,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic             WrRegDSrc,
    output logic             ExtSel,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegDst,
    output logic [2:0]       ALUOp,
    output logic [3:0]       state_o,
    output logic             retire,
    output logic [RET_W-1:0] ret_cnt,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_EXE_R = 4'd2, S_EXE_B = 4'd3, S_EXE_M = 4'd4,
        S_MEM = 4'd5, S_WB_R = 4'd6, S_WB_L = 4'd7, S_HALT = 4'd8, S_ERR = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_ALU = 3'd0, C_BR = 3'd1, C_MEM = 3'd2, C_JMP = 3'd3, C_HALT = 3'd4, C_ILL = 3'd5
    } op_class_t;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b010000, OP_ANDI = 6'b010001, OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI = 6'b010011, OP_SLL  = 6'b011000, OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b100111, OP_SW   = 6'b110000, OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100, OP_BNE  = 6'b110101, OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT_CYC);
    localparam logic             TMO_EN  = (TIMEOUT_CYC != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [RET_W-1:0]  ret_cnt_q;
    logic [1:0]        err_code_q, err_code_d;

    op_class_t         cls_s;
    logic              src_a_s, src_b_s, db_src_s, wr_src_s, ext_s;
    logic [1:0]        pc_src_s, reg_dst_s;
    logic [2:0]        alu_op_s;
    logic              pcwre_s, irwre_s, regwre_s, mrd_s, mwr_s, retire_s;
    logic              tmo_hit_s;

    assign tmo_hit_s = TMO_EN && (wait_q == TMO_V);

    // Static per-opcode datapath fields and instruction class.
    always_comb begin
        cls_s     = C_ALU;
        src_a_s   = 1'b0;
        src_b_s   = 1'b0;
        db_src_s  = 1'b0;
        wr_src_s  = 1'b1;
        ext_s     = 1'b0;
        pc_src_s  = 2'b00;
        reg_dst_s = 2'b00;
        alu_op_s  = 3'b000;
        case (opcode)
            OP_ADD:   begin reg_dst_s = 2'b10; alu_op_s = 3'b000; end
            OP_SUB:   begin reg_dst_s = 2'b10; alu_op_s = 3'b001; end
            OP_ADDIU: begin src_b_s = 1'b1; ext_s = 1'b1; reg_dst_s = 2'b01; end
            OP_AND:   begin reg_dst_s = 2'b10; alu_op_s = 3'b100; end
            OP_ANDI:  begin src_b_s = 1'b1; reg_dst_s = 2'b01; alu_op_s = 3'b100; end
            OP_ORI:   begin src_b_s = 1'b1; reg_dst_s = 2'b01; alu_op_s = 3'b011; end
            OP_XORI:  begin src_b_s = 1'b1; reg_dst_s = 2'b01; alu_op_s = 3'b111; end
            OP_SLL:   begin src_a_s = 1'b1; reg_dst_s = 2'b10; alu_op_s = 3'b010; end
            OP_SLTI:  begin src_b_s = 1'b1; ext_s = 1'b1; reg_dst_s = 2'b01; alu_op_s = 3'b110; end
            OP_SLT:   begin reg_dst_s = 2'b10; alu_op_s = 3'b110; end
            OP_SW:    begin cls_s = C_MEM; src_b_s = 1'b1; ext_s = 1'b1; end
            OP_LW:    begin cls_s = C_MEM; src_b_s = 1'b1; db_src_s = 1'b1; ext_s = 1'b1; reg_dst_s = 2'b01; end
            OP_BEQ:   begin cls_s = C_BR; ext_s = 1'b1; alu_op_s = 3'b001; pc_src_s = zero ? 2'b01 : 2'b00; end
            OP_BNE:   begin cls_s = C_BR; ext_s = 1'b1; alu_op_s = 3'b001; pc_src_s = zero ? 2'b00 : 2'b01; end
            OP_BLTZ:  begin cls_s = C_BR; ext_s = 1'b1; pc_src_s = sign ? 2'b01 : 2'b00; end
            OP_J:     begin cls_s = C_JMP; pc_src_s = 2'b11; end
            OP_JR:    begin cls_s = C_JMP; pc_src_s = 2'b10; end
            OP_JAL:   begin cls_s = C_JMP; pc_src_s = 2'b11; wr_src_s = 1'b0; end
            OP_HALT:  begin cls_s = C_HALT; wr_src_s = 1'b0; end
            default:  begin cls_s = C_ILL; wr_src_s = 1'b0; end
        endcase
    end

    // Next-state, wait counter, error code and state-qualified strobes.
    always_comb begin
        state_d    = state_q;
        wait_d     = {CNT_W{1'b0}};
        err_code_d = err_code_q;
        pcwre_s    = 1'b0;
        irwre_s    = 1'b0;
        regwre_s   = 1'b0;
        mrd_s      = 1'b0;
        mwr_s      = 1'b0;
        retire_s   = 1'b0;
        case (state_q)
            S_IF: begin
                if (imem_ready) begin
                    irwre_s = 1'b1;
                    state_d = S_ID;
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_ID: begin
                case (cls_s)
                    C_JMP: begin
                        pcwre_s  = 1'b1;
                        retire_s = 1'b1;
                        regwre_s = (opcode == OP_JAL);
                        state_d  = S_IF;
                    end
                    C_HALT:  state_d = S_HALT;
                    C_BR:    state_d = S_EXE_B;
                    C_MEM:   state_d = S_EXE_M;
                    C_ALU:   state_d = S_EXE_R;
                    default: begin
                        state_d    = S_ERR;
                        err_code_d = 2'b01;
                    end
                endcase
            end
            S_EXE_R: state_d = S_WB_R;
            S_EXE_B: begin
                pcwre_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = S_IF;
            end
            S_EXE_M: state_d = S_MEM;
            S_MEM: begin
                if (dmem_ready) begin
                    mrd_s = (opcode == OP_LW);
                    mwr_s = (opcode != OP_LW);
                    if (opcode == OP_LW) begin
                        state_d = S_WB_L;
                    end else begin
                        pcwre_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = S_IF;
                    end
                end else if (tmo_hit_s) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b11;
                end else begin
                    mrd_s  = (opcode == OP_LW);
                    mwr_s  = (opcode != OP_LW);
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB_R, S_WB_L: begin
                regwre_s = 1'b1;
                pcwre_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // State, wait counter, retire counter and error code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IF;
            wait_q     <= {CNT_W{1'b0}};
            ret_cnt_q  <= {RET_W{1'b0}};
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ret_cnt_q  <= retire_s ? ret_cnt_q + RET_W'(1) : ret_cnt_q;
            err_code_q <= err_code_d;
        end
    end

    assign InsMemRW  = 1'b1;
    assign PCWre     = ~rst & pcwre_s;
    assign IRWre     = ~rst & irwre_s;
    assign RegWre    = ~rst & regwre_s;
    assign mRD       = ~rst & mrd_s;
    assign mWR       = ~rst & mwr_s;
    assign retire    = ~rst & retire_s;
    assign ALUSrcA   = ~rst & src_a_s;
    assign ALUSrcB   = ~rst & src_b_s;
    assign DBDataSrc = ~rst & db_src_s;
    assign WrRegDSrc = ~rst & wr_src_s;
    assign ExtSel    = ~rst & ext_s;
    assign PCSrc     = rst ? 2'b00 : pc_src_s;
    assign RegDst    = rst ? 2'b00 : reg_dst_s;
    assign ALUOp     = rst ? 3'b000 : alu_op_s;
    assign state_o   = state_q;
    assign ret_cnt   = ret_cnt_q;
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERR);
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// Directed testbench for mc_control_unit_v2 (TIMEOUT_CYC=4, RET_W=2).
module tb_mc_control_unit_v2;

    localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXE_R = 4'd2, S_EXE_B = 4'd3, S_EXE_M = 4'd4;
    localparam logic [3:0] S_MEM = 4'd5, S_WB_R = 4'd6, S_WB_L = 4'd7, S_HALT = 4'd8, S_ERR = 4'd9;
    localparam logic [5:0] OP_ADD = 6'b000000, OP_LW = 6'b110001, OP_SW = 6'b110000;
    localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J = 6'b111000, OP_JAL = 6'b111010, OP_HALT = 6'b111111;
    // strobe vector order: {PCWre, IRWre, RegWre, mRD, mWR, retire}
    localparam logic [5:0] SB_NONE = 6'b000000, SB_IR = 6'b010000, SB_RET = 6'b100001;
    localparam logic [5:0] SB_WB = 6'b101001, SB_RD = 6'b000100, SB_WR = 6'b000010, SB_SWDONE = 6'b100011;

    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic zero = 1'b0, sign = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic InsMemRW, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0] PCSrc, RegDst, err_code;
    logic [2:0] ALUOp;
    logic [3:0] state_o;
    logic retire, halted, err;
    logic [1:0] ret_cnt;
    logic [5:0] strb;
    logic [11:0] flds;
    int n_chk = 0, n_pass = 0;

    mc_control_unit_v2 #(.TIMEOUT_CYC(4), .CNT_W(5), .RET_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .sign(sign),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .InsMemRW(InsMemRW),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp), .state_o(state_o),
        .retire(retire), .ret_cnt(ret_cnt), .halted(halted), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    assign strb = {PCWre, IRWre, RegWre, mRD, mWR, retire};
    assign flds = {ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, PCSrc, RegDst, ALUOp};

    function automatic logic [11:0] fld(input logic a, input logic b, input logic db, input logic wr,
                                        input logic ext, input logic [1:0] pcs, input logic [1:0] rd,
                                        input logic [2:0] op);
        return {a, b, db, wr, ext, pcs, rd, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [5:0] op, input logic ir, input logic dr, input logic z, input logic s);
        opcode = op; imem_ready = ir; dmem_ready = dr; zero = z; sign = s;
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [5:0] sb);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".strobes"}, 32'(strb), 32'(sb));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.state", 32'(state_o), 32'(S_IF));
        check("rst.strobes", 32'(strb), 32'(SB_NONE));
        check("rst.cnt", 32'(ret_cnt), 32'd0);
        check("rst.err", 32'({err, halted, err_code}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        drive(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset.state", 32'(state_o), 32'(S_IF));
        check("reset.strobes", 32'(strb), 32'(SB_NONE));
        check("reset.fields", 32'(flds), 32'd0);
        check("reset.insmemrw", 32'(InsMemRW), 32'd1);
        check("reset.status", 32'({ret_cnt, halted, err, err_code}), 32'd0);
        rst = 1'b0;
        #1;
        // add, zero wait: IF ID EXE_R WB_R
        step("add.if", S_IF, SB_IR);
        step("add.id", S_ID, SB_NONE);
        step("add.exr", S_EXE_R, SB_NONE);
        check("add.fields", 32'(flds), 32'(fld(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 3'b000)));
        step("add.wbr", S_WB_R, SB_WB);
        check("add.cnt", 32'(ret_cnt), 32'd1);
        // lw with three dmem wait states
        drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lw.if", S_IF, SB_IR);
        step("lw.id", S_ID, SB_NONE);
        step("lw.exm", S_EXE_M, SB_NONE);
        for (int i = 0; i < 3; i++) step("lw.memwait", S_MEM, SB_RD);
        drive(OP_LW, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lw.fields", 32'(flds), 32'(fld(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 3'b000)));
        step("lw.memrdy", S_MEM, SB_RD);
        step("lw.wbl", S_WB_L, SB_WB);
        check("lw.cnt", 32'(ret_cnt), 32'd2);
        // beq taken, bne not taken, bltz taken
        drive(OP_BEQ, 1'b1, 1'b1, 1'b1, 1'b0);
        step("beq.if", S_IF, SB_IR);
        step("beq.id", S_ID, SB_NONE);
        check("beq.pcsrc", 32'(PCSrc), 32'd1);
        step("beq.exb", S_EXE_B, SB_RET);
        drive(OP_BNE, 1'b1, 1'b1, 1'b1, 1'b0);
        step("bne.if", S_IF, SB_IR);
        step("bne.id", S_ID, SB_NONE);
        check("bne.pcsrc", 32'(PCSrc), 32'd0);
        step("bne.exb", S_EXE_B, SB_RET);
        check("bne.cnt_wrap", 32'(ret_cnt), 32'd0);
        drive(OP_BLTZ, 1'b1, 1'b1, 1'b0, 1'b1);
        step("bltz.if", S_IF, SB_IR);
        step("bltz.id", S_ID, SB_NONE);
        check("bltz.pcsrc", 32'(PCSrc), 32'd1);
        step("bltz.exb", S_EXE_B, SB_RET);
        check("ret5.cnt", 32'(ret_cnt), 32'd1);
        // jal: two cycles, link write in ID
        drive(OP_JAL, 1'b1, 1'b1, 1'b0, 1'b0);
        step("jal.if", S_IF, SB_IR);
        check("jal.fields", 32'(flds), 32'(fld(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b000)));
        step("jal.id", S_ID, SB_WB);
        check("jal.cnt", 32'(ret_cnt), 32'd2);
        // sw zero wait
        drive(OP_SW, 1'b1, 1'b1, 1'b0, 1'b0);
        step("sw.if", S_IF, SB_IR);
        step("sw.id", S_ID, SB_NONE);
        check("sw.fields", 32'(flds), 32'(fld(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'b000)));
        step("sw.exm", S_EXE_M, SB_NONE);
        step("sw.mem", S_MEM, SB_SWDONE);
        check("sw.cnt", 32'(ret_cnt), 32'd3);
        // ready arriving as the counter hits the limit wins
        drive(OP_J, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("win.ifwait", S_IF, SB_NONE);
        drive(OP_J, 1'b1, 1'b1, 1'b0, 1'b0);
        step("win.ifrdy", S_IF, SB_IR);
        check("j.pcsrc", 32'(PCSrc), 32'd3);
        step("win.id", S_ID, SB_RET);
        check("win.cnt", 32'(ret_cnt), 32'd0);
        // sw dmem timeout
        drive(OP_SW, 1'b1, 1'b0, 1'b0, 1'b0);
        step("swto.if", S_IF, SB_IR);
        step("swto.id", S_ID, SB_NONE);
        step("swto.exm", S_EXE_M, SB_NONE);
        for (int i = 0; i < 4; i++) step("swto.memwait", S_MEM, SB_WR);
        step("swto.memto", S_MEM, SB_NONE);
        drive(OP_SW, 1'b1, 1'b1, 1'b0, 1'b0);
        check("swto.err", 32'({err, halted, err_code}), 32'b1011);
        step("swto.err1", S_ERR, SB_NONE);
        step("swto.err2", S_ERR, SB_NONE);
        do_reset();
        // imem timeout
        drive(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("ifto.ifwait", S_IF, SB_NONE);
        check("ifto.err", 32'({err, halted, err_code}), 32'b1010);
        step("ifto.err1", S_ERR, SB_NONE);
        drive(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ifto.err2", S_ERR, SB_NONE);
        do_reset();
        // illegal opcode
        drive(6'b000111, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ill.if", S_IF, SB_IR);
        step("ill.id", S_ID, SB_NONE);
        check("ill.err", 32'({err, halted, err_code}), 32'b1001);
        step("ill.err1", S_ERR, SB_NONE);
        do_reset();
        // halt
        drive(OP_HALT, 1'b1, 1'b1, 1'b0, 1'b0);
        step("halt.if", S_IF, SB_IR);
        step("halt.id", S_ID, SB_NONE);
        check("halt.flags", 32'({err, halted}), 32'b01);
        step("halt.h1", S_HALT, SB_NONE);
        step("halt.h2", S_HALT, SB_NONE);
        check("halt.cnt", 32'(ret_cnt), 32'd0);
        do_reset();
        // reset mid-MEM of sw aborts the write strobe at once
        drive(OP_J, 1'b1, 1'b1, 1'b0, 1'b0);
        step("pre.if", S_IF, SB_IR);
        step("pre.id", S_ID, SB_RET);
        drive(OP_SW, 1'b1, 1'b0, 1'b0, 1'b0);
        step("abort.if", S_IF, SB_IR);
        step("abort.id", S_ID, SB_NONE);
        step("abort.exm", S_EXE_M, SB_NONE);
        check("abort.mem_mwr", 32'(strb), 32'(SB_WR));
        check("abort.cnt_pre", 32'(ret_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.strobes", 32'(strb), 32'(SB_NONE));
        check("abort.state", 32'(state_o), 32'(S_IF));
        check("abort.cnt", 32'(ret_cnt), 32'd0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
